// File: rtl/dmem_sized.sv
// Byte-addressed data memory for the MEM stage: sized stores with lane masks,
// extended sub-word loads, programmable wait states and alignment checking.
module dmem_sized #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_LOG2  = 9,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic                  memread,
    input  logic                  memwrite,
    input  logic [1:0]            size,
    input  logic                  load_unsigned,
    output logic [31:0]           rdata,
    output logic                  ready,
    output logic                  misalign,
    output logic                  busy
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    state_t                r_state, w_next_state;
    logic [3:0]            r_cnt, w_next_cnt;
    logic [DEPTH_LOG2-1:0] r_word;
    logic [1:0]            r_lane, r_size;
    logic [31:0]           r_wdata;
    logic                  r_uns, r_write;
    logic [31:0]           r_rdata;
    logic                  r_err;
    logic [31:0]           r_mem [2**DEPTH_LOG2];

    logic                  w_accept, w_commit, w_from_regs;
    logic [DEPTH_LOG2-1:0] w_word;
    logic [1:0]            w_lane, w_size;
    logic [31:0]           w_wdata, w_mem_word, w_load, w_wvec;
    logic                  w_uns, w_write, w_err;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [3:0]            w_wmask;
    logic                  w_unused_addr;

    assign w_unused_addr = ^addr[ADDR_WIDTH-1:DEPTH_LOG2+2];

    assign w_accept = (r_state != S_WAIT) && (memread || memwrite);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_next_state = S_IDLE;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_WAIT;
                    w_next_cnt   = r_cnt - 4'd1;
                end
            end
            default: begin
                if (w_accept) begin
                    if (WAIT_STATES == 0) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_next_state = S_WAIT;
                        w_next_cnt   = CNT_INIT;
                    end
                end
            end
        endcase
    end

    // With zero wait states the commit edge is the accept edge, so take live inputs.
    assign w_commit    = (w_next_state == S_DONE);
    assign w_from_regs = (r_state == S_WAIT);
    assign w_word      = w_from_regs ? r_word  : addr[DEPTH_LOG2+1:2];
    assign w_lane      = w_from_regs ? r_lane  : addr[1:0];
    assign w_size      = w_from_regs ? r_size  : size;
    assign w_wdata     = w_from_regs ? r_wdata : wdata;
    assign w_uns       = w_from_regs ? r_uns   : load_unsigned;
    assign w_write     = w_from_regs ? r_write : memwrite;

    assign w_err = (w_size == 2'b11)
                || (w_size == 2'b01 && w_lane[0])
                || (w_size == 2'b10 && w_lane != 2'b00);

    assign w_mem_word = r_mem[w_word];
    assign w_byte     = w_mem_word[{w_lane, 3'b000} +: 8];
    assign w_half     = w_lane[1] ? w_mem_word[31:16] : w_mem_word[15:0];

    always_comb begin
        w_load  = '0;
        w_wmask = 4'b0000;
        w_wvec  = w_wdata;
        case (w_size)
            2'b00: begin
                w_load  = {{24{~w_uns & w_byte[7]}}, w_byte};
                w_wmask = 4'b0001 << w_lane;
                w_wvec  = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_load  = {{16{~w_uns & w_half[15]}}, w_half};
                w_wmask = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wvec  = {2{w_wdata[15:0]}};
            end
            2'b10: begin
                w_load  = w_mem_word;
                w_wmask = 4'b1111;
            end
            default: ;
        endcase
    end

    // NOTE: the array has no reset; contents survive rst_n and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_commit && w_write && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wmask[i]) r_mem[w_word][8*i +: 8] <= w_wvec[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_word  <= '0;
            r_lane  <= 2'b00;
            r_size  <= 2'b00;
            r_wdata <= '0;
            r_uns   <= 1'b0;
            r_write <= 1'b0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_word  <= addr[DEPTH_LOG2+1:2];
                r_lane  <= addr[1:0];
                r_size  <= size;
                r_wdata <= wdata;
                r_uns   <= load_unsigned;
                r_write <= memwrite;
            end
            if (w_commit) begin
                r_err   <= w_err;
                r_rdata <= (w_write || w_err) ? 32'd0 : w_load;
            end
        end
    end

    assign rdata    = r_rdata;
    assign ready    = (r_state == S_DONE);
    assign misalign = (r_state == S_DONE) && r_err;
    assign busy     = (r_state == S_WAIT);

endmodule

// File: doc/dmem_sized.md
# dmem_sized

Parametrised data memory for the pipelined MIPS datapath, successor to the fixed word-only data RAM. Supports byte/halfword/word stores with byte-lane masking, sign- or zero-extended sub-word loads, a configurable number of wait states with a ready handshake, and misalignment detection. Sits in the MEM stage; the pipeline stalls on `busy` and consumes `rdata` when `ready` pulses.

## Interface
- `ADDR_WIDTH`, 32, byte-address width.
- `DEPTH_LOG2`, 9, log2 of the number of 32-bit words (512 words by default).
- `WAIT_STATES`, 0, extra cycles per access (0..15).
- `clk` in 1: single clock, all state updates on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `addr` in ADDR_WIDTH: byte address. Word index is `addr[DEPTH_LOG2+1:2]` and lane is `addr[1:0]`. Upper bits are ignored (aliasing).
- `wdata` in 32: store data, right-justified (SB uses `[7:0]`, SH uses `[15:0]`).
- `memread` in 1: load request.
- `memwrite` in 1: store request. Has priority over `memread`.
- `size` in 2: 00 = byte, 01 = half, 10 = word, 11 = reserved (error).
- `load_unsigned` in 1: 1 = zero-extend sub-word loads, 0 = sign-extend.
- `rdata` out 32: load result, valid when `ready`=1. Holds its value otherwise.
- `ready` out 1: one-cycle completion pulse.
- `misalign` out 1: error flag, valid with `ready`.
- `busy` out 1: high while in WAIT. Requests are ignored while `busy`=1.

## Operation
- FSM states:
  - IDLE: reset state, no access in flight.
  - WAIT: counting down wait states.
  - DONE: `ready`=1 for exactly this cycle.
- Accept: at a posedge with state ≠ WAIT and (`memread`|`memwrite`), capture addr/wdata/size/load_unsigned/op into request registers.
  - If WAIT_STATES=0, go to DONE.
  - Otherwise go to WAIT with the counter set to WAIT_STATES-1.
- WAIT: decrement the counter each cycle. When it reaches 0, go to DONE on the next edge.
- DONE: if a new request is present, accept it using the same transitions as IDLE; otherwise go to IDLE.
- Commit: on the edge entering DONE, perform the captured op.
  - Store: write only the enabled lanes, little-endian (lane 0 = bits [7:0]).
    - SB: `wdata[7:0]` into lane `addr[1:0]`.
    - SH: `wdata[15:0]` into lanes {a1,0},{a1,1}.
    - SW: all 4 lanes.
    - Lanes not enabled are unchanged.
  - Load: read the word, select the byte or half, extend per `load_unsigned`, and register into `rdata`.
  - Store completion: `rdata` is set to 0.
- Errors: any of the following is an error:
  - half with `addr[0]`=1,
  - word with `addr[1:0]`≠0,
  - `size`=11.
  - On error: no memory write, `rdata`=0, `misalign`=1 during DONE, and `ready` still pulses.
- `misalign` is 0 in every cycle that is not DONE.
- If both `memread` and `memwrite` are high, the request is a store; the read is dropped.
- Memory array contents are not reset and are unaffected by `rst_n`.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0): state IDLE, `rdata`=0, `ready`=0, `misalign`=0, `busy`=0, counter 0.
- Latency: `ready` is high (1+WAIT_STATES) cycles after the accepting edge.
- Throughput:
  - WAIT_STATES=0: one access per cycle, including back-to-back accepts in DONE.
  - Otherwise: one access per (WAIT_STATES+1) cycles.
- Store-then-load to the same address, back-to-back: the load returns the new data, because the commit is ordered.
- Reset asserted mid-access: the pending store is discarded (not committed), `ready` is not pulsed, and the FSM returns to IDLE.
- Inputs are sampled only at accept; changes during WAIT have no effect.

## Test plan
- WAIT_STATES=0: SW 0xDEADBEEF @0x10, then LW @0x10 -> `ready` 1 cycle after each accept, `rdata`=0xDEADBEEF, `misalign`=0.
- Byte-lane merge: SW 0x11223344 @0x20, SB 0xAA @0x23, SH 0x5566 @0x20, then LW @0x20 -> 0xAA225566.
- Extension: SB 0x80 @0x30.
  - LB @0x30 -> 0xFFFFFF80.
  - LBU -> 0x00000080.
  - SH 0x8001 @0x32, then LH @0x32 -> 0xFFFF8001.
- Errors:
  - SW @0x42 -> `ready`=1, `misalign`=1, `rdata`=0, and LW @0x40 is unchanged.
  - LH @0x41 -> `misalign`=1.
  - `size`=11 -> `misalign`=1.
- WAIT_STATES=2: LW accepted at cycle t -> `busy`=1 in t+1..t+2, `ready` at t+3; a request in t+1 is ignored; a request at t+3 is accepted, with `ready` at t+6.
- Reset mid-op: with WAIT_STATES=2, SW 0x12345678 @0x50, then drop `rst_n` in WAIT -> outputs 0 immediately, no `ready`; a later LW @0x50 returns the previous contents.
